// File: rtl/round_controller_if.sv
// Signal bundle between the round controller and the card datapath / player-facing logic.
// The controller drives through the master modport; the datapath and display side use the slave modport.
interface round_controller_if #(
    parameter int TIMER_W = 28,
    parameter int SCORE_W = 8
);
    logic               start;
    logic               key_right;
    logic               key_wrong;
    logic               expected_match;
    logic               card_advance;
    logic               answer_window;
    logic               answer_correct;
    logic               game_over;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] best_score;
    logic [TIMER_W-1:0] period;
    logic [2:0]         state;

    modport master (
        input  start, key_right, key_wrong, expected_match,
        output card_advance, answer_window, answer_correct, game_over,
        output score, best_score, period, state
    );

    modport slave (
        output start, key_right, key_wrong, expected_match,
        input  card_advance, answer_window, answer_correct, game_over,
        input  score, best_score, period, state
    );
endinterface

// File: rtl/round_controller.sv
// Memory-game round sequencer: card timing, answer window, judging, scoring and speed-up.
// Card cadence: one period of first-card display, then period+2 cycles per correctly answered card.
module round_controller #(
    parameter int TIMER_W         = 28,
    parameter int PERIOD_INIT     = 149999999,
    parameter int PERIOD_STEP     = 25000000,
    parameter int PERIOD_MIN      = 50000000,
    parameter int LEVEL_UP_STREAK = 4,
    parameter int SCORE_W         = 8
) (
    input  logic               clk,
    input  logic               reset,
    round_controller_if.master bus
);
    localparam int STREAK_W = $clog2(LEVEL_UP_STREAK + 1);
    localparam logic [TIMER_W:0] STEP_THRESH = (TIMER_W + 1)'(PERIOD_MIN + PERIOD_STEP);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SHOW_FIRST = 3'd1,
        ANSWER     = 3'd2,
        JUDGE      = 3'd3,
        CORRECT    = 3'd4,
        OVER       = 3'd5
    } state_t;

    state_t               state_reg, state_next;
    logic [TIMER_W-1:0]   timer_reg, timer_next;
    logic [TIMER_W-1:0]   period_reg, period_next;
    logic [SCORE_W-1:0]   score_reg, score_next;
    logic [SCORE_W-1:0]   best_reg, best_next;
    logic [STREAK_W-1:0]  streak_reg, streak_next;
    logic [STREAK_W-1:0]  streak_inc;
    logic                 ans_taken_reg, ans_taken_next;
    logic                 ans_value_reg, ans_value_next;
    logic                 ans_invalid_reg, ans_invalid_next;
    logic                 card_adv_reg, card_adv_next;
    logic                 start_prev_reg, right_prev_reg, wrong_prev_reg;

    logic start_edge, right_edge, wrong_edge;

    assign start_edge = bus.start     & ~start_prev_reg;
    assign right_edge = bus.key_right & ~right_prev_reg;
    assign wrong_edge = bus.key_wrong & ~wrong_prev_reg;
    assign streak_inc = streak_reg + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            timer_reg       <= '0;
            period_reg      <= TIMER_W'(PERIOD_INIT);
            score_reg       <= '0;
            best_reg        <= '0;
            streak_reg      <= '0;
            ans_taken_reg   <= 1'b0;
            ans_value_reg   <= 1'b0;
            ans_invalid_reg <= 1'b0;
            card_adv_reg    <= 1'b0;
            // Inputs already high at reset release must not look like fresh presses.
            start_prev_reg  <= 1'b1;
            right_prev_reg  <= 1'b1;
            wrong_prev_reg  <= 1'b1;
        end else begin
            state_reg       <= state_next;
            timer_reg       <= timer_next;
            period_reg      <= period_next;
            score_reg       <= score_next;
            best_reg        <= best_next;
            streak_reg      <= streak_next;
            ans_taken_reg   <= ans_taken_next;
            ans_value_reg   <= ans_value_next;
            ans_invalid_reg <= ans_invalid_next;
            card_adv_reg    <= card_adv_next;
            start_prev_reg  <= bus.start;
            right_prev_reg  <= bus.key_right;
            wrong_prev_reg  <= bus.key_wrong;
        end
    end

    always_comb begin
        state_next       = state_reg;
        timer_next       = timer_reg;
        period_next      = period_reg;
        score_next       = score_reg;
        best_next        = best_reg;
        streak_next      = streak_reg;
        ans_taken_next   = ans_taken_reg;
        ans_value_next   = ans_value_reg;
        ans_invalid_next = ans_invalid_reg;
        card_adv_next    = 1'b0;

        case (state_reg)
            IDLE, OVER: begin
                if (start_edge) begin
                    period_next   = TIMER_W'(PERIOD_INIT);
                    score_next    = '0;
                    streak_next   = '0;
                    timer_next    = TIMER_W'(PERIOD_INIT - 1);
                    card_adv_next = 1'b1;
                    state_next    = SHOW_FIRST;
                end
            end

            SHOW_FIRST: begin
                if (timer_reg == '0) begin
                    timer_next       = period_reg - 1'b1;
                    ans_taken_next   = 1'b0;
                    ans_value_next   = 1'b0;
                    ans_invalid_next = 1'b0;
                    card_adv_next    = 1'b1;
                    state_next       = ANSWER;
                end else begin
                    timer_next = timer_reg - 1'b1;
                end
            end

            ANSWER: begin
                // Only the first press counts; the window always runs its full length.
                if (!ans_taken_reg && (right_edge || wrong_edge)) begin
                    ans_taken_next   = 1'b1;
                    ans_value_next   = right_edge;
                    ans_invalid_next = right_edge && wrong_edge;
                end
                if (timer_reg == '0) begin
                    state_next = JUDGE;
                end else begin
                    timer_next = timer_reg - 1'b1;
                end
            end

            JUDGE: begin
                if (ans_taken_reg && !ans_invalid_reg && (ans_value_reg == bus.expected_match)) begin
                    state_next = CORRECT;
                end else begin
                    if (score_reg > best_reg) begin
                        best_next = score_reg;
                    end
                    state_next = OVER;
                end
            end

            CORRECT: begin
                if (score_reg != '1) begin
                    score_next = score_reg + 1'b1;
                end
                if (streak_inc == STREAK_W'(LEVEL_UP_STREAK)) begin
                    streak_next = '0;
                    if ({1'b0, period_reg} >= STEP_THRESH) begin
                        period_next = period_reg - TIMER_W'(PERIOD_STEP);
                    end else begin
                        period_next = TIMER_W'(PERIOD_MIN);
                    end
                end else begin
                    streak_next = streak_inc;
                end
                timer_next       = period_next - 1'b1;
                ans_taken_next   = 1'b0;
                ans_value_next   = 1'b0;
                ans_invalid_next = 1'b0;
                card_adv_next    = 1'b1;
                state_next       = ANSWER;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.card_advance   = card_adv_reg;
    assign bus.answer_window  = (state_reg == ANSWER);
    assign bus.answer_correct = (state_reg == CORRECT);
    assign bus.game_over      = (state_reg == OVER);
    assign bus.score          = score_reg;
    assign bus.best_score     = best_reg;
    assign bus.period         = period_reg;
    assign bus.state          = state_reg;
endmodule
